// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the I/D cache miss arbiter and its block word counter.
package cache_arb_pkg;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 16;
    localparam int BLK_WORDS  = 8;
    localparam int WORD_IDX_W = 3;
    localparam int BLK_BASE_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FILL  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    typedef enum logic {
        TGT_I = 1'b0,
        TGT_D = 1'b1
    } fill_tgt_e;

    // Byte address of one 16-bit word inside a 16-byte block.
    function automatic logic [ADDR_W-1:0] blk_word_addr(input logic [BLK_BASE_W-1:0] base,
                                                        input logic [WORD_IDX_W-1:0] idx);
        return {base, idx, 1'b0};
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

endpackage

// File: rtl/cache_miss_arbiter_blk_word_counter.sv
// Word index within a cache block: synchronous clear, increment, and a last-word flag.
module blk_word_counter
    import cache_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  inc,
    output logic [WORD_IDX_W-1:0] cnt,
    output logic                  last
);

    logic [WORD_IDX_W-1:0] cnt_q, cnt_d;

    // Next count: clear wins over increment.
    always_comb begin
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 3'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == 3'(BLK_WORDS - 1));

endmodule

// File: rtl/cache_miss_arbiter.sv
// Shares memory4c between I/D block fills and D write-through stores.
// Optional performance counters are enabled by defining CACHE_ARB_PERF_EN.
module cache_miss_arbiter
    import cache_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_miss_addr,
    input  logic              d_miss,
    input  logic [ADDR_W-1:0] d_miss_addr,
    input  logic              d_wr_req,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [DATA_W-1:0] d_wr_data,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid,
    output logic [DATA_W-1:0] fill_data,
    output logic [ADDR_W-1:0] fill_addr,
    output logic              i_data_we,
    output logic              i_meta_we,
    output logic              d_data_we,
    output logic              d_meta_we,
`ifdef CACHE_ARB_PERF_EN
    output logic [15:0]       i_fill_cnt,
    output logic [15:0]       d_fill_cnt,
    output logic [15:0]       stall_cyc,
`endif
    output logic              stall
);

    arb_state_e            state_q, state_d;
    fill_tgt_e             tgt_q, tgt_d;
    logic [BLK_BASE_W-1:0] base_q, base_d;
    logic                  issue_on_q, issue_on_d;
    logic                  mem_en_q, mem_en_d, mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d, fill_addr_q, fill_addr_d;
    logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d, fill_data_q, fill_data_d;
    logic                  i_data_we_q, i_data_we_d, i_meta_we_q, i_meta_we_d;
    logic                  d_data_we_q, d_data_we_d, d_meta_we_q, d_meta_we_d;
    logic                  cnt_clr_s, issue_inc_s, recv_inc_s, issue_last_s, recv_last_s;
    logic [WORD_IDX_W-1:0] issue_cnt_s, recv_cnt_s;
    logic                  unused_s;

    assign unused_s  = ^{i_miss_addr[3:0], d_miss_addr[3:0]};
    assign cnt_clr_s = (state_q != ST_FILL);

    blk_word_counter u_issue_cnt (
        .clk (clk), .rst_n (rst_n), .clr (cnt_clr_s), .inc (issue_inc_s),
        .cnt (issue_cnt_s), .last (issue_last_s)
    );

    blk_word_counter u_recv_cnt (
        .clk (clk), .rst_n (rst_n), .clr (cnt_clr_s), .inc (recv_inc_s),
        .cnt (recv_cnt_s), .last (recv_last_s)
    );

    // Next state and next-cycle outputs; outputs are registered, so word 0 is issued on FILL entry.
    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        base_d      = base_q;
        issue_on_d  = 1'b0;
        mem_en_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        fill_data_d = '0;
        fill_addr_d = '0;
        i_data_we_d = 1'b0;
        i_meta_we_d = 1'b0;
        d_data_we_d = 1'b0;
        d_meta_we_d = 1'b0;
        issue_inc_s = 1'b0;
        recv_inc_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (d_wr_req) begin
                    state_d     = ST_WRITE;
                    mem_en_d    = 1'b1;
                    mem_wr_d    = 1'b1;
                    mem_addr_d  = d_wr_addr;
                    mem_wdata_d = d_wr_data;
                end else if (d_miss) begin
                    state_d    = ST_FILL;
                    tgt_d      = TGT_D;
                    base_d     = d_miss_addr[ADDR_W-1 -: BLK_BASE_W];
                    issue_on_d = 1'b1;
                    mem_en_d   = 1'b1;
                    mem_addr_d = blk_word_addr(d_miss_addr[ADDR_W-1 -: BLK_BASE_W], 3'd0);
                end else if (i_miss) begin
                    state_d    = ST_FILL;
                    tgt_d      = TGT_I;
                    base_d     = i_miss_addr[ADDR_W-1 -: BLK_BASE_W];
                    issue_on_d = 1'b1;
                    mem_en_d   = 1'b1;
                    mem_addr_d = blk_word_addr(i_miss_addr[ADDR_W-1 -: BLK_BASE_W], 3'd0);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            ST_FILL: begin
                if (issue_on_q && !issue_last_s) begin
                    issue_on_d  = 1'b1;
                    issue_inc_s = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_addr_d  = blk_word_addr(base_q, issue_cnt_s + 3'd1);
                end else begin
                    issue_on_d = 1'b0;
                end
                if (mem_valid) begin
                    recv_inc_s  = 1'b1;
                    fill_data_d = mem_rdata;
                    fill_addr_d = blk_word_addr(base_q, recv_cnt_s);
                    if (tgt_q == TGT_D) begin
                        d_data_we_d = 1'b1;
                        d_meta_we_d = recv_last_s;
                    end else begin
                        i_data_we_d = 1'b1;
                        i_meta_we_d = recv_last_s;
                    end
                    state_d = recv_last_s ? ST_DONE : ST_FILL;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops every enable so an aborted block stays invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tgt_q       <= TGT_I;
            base_q      <= '0;
            issue_on_q  <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            fill_data_q <= '0;
            fill_addr_q <= '0;
            i_data_we_q <= 1'b0;
            i_meta_we_q <= 1'b0;
            d_data_we_q <= 1'b0;
            d_meta_we_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            base_q      <= base_d;
            issue_on_q  <= issue_on_d;
            mem_en_q    <= mem_en_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            fill_data_q <= fill_data_d;
            fill_addr_q <= fill_addr_d;
            i_data_we_q <= i_data_we_d;
            i_meta_we_q <= i_meta_we_d;
            d_data_we_q <= d_data_we_d;
            d_meta_we_q <= d_meta_we_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign fill_data = fill_data_q;
    assign fill_addr = fill_addr_q;
    assign i_data_we = i_data_we_q;
    assign i_meta_we = i_meta_we_q;
    assign d_data_we = d_data_we_q;
    assign d_meta_we = d_meta_we_q;

    // Pipeline must freeze in the same cycle a miss appears; reset forces it low.
    assign stall = rst_n & ((state_q != ST_IDLE) | i_miss | d_miss);

`ifdef CACHE_ARB_PERF_EN
    logic [15:0] i_fill_cnt_q, i_fill_cnt_d, d_fill_cnt_q, d_fill_cnt_d;
    logic [15:0] stall_cyc_q, stall_cyc_d;
    logic        fill_done_s;

    assign fill_done_s = (state_q == ST_FILL) && (state_d == ST_DONE);

    // Saturating event counters.
    always_comb begin
        i_fill_cnt_d = i_fill_cnt_q;
        d_fill_cnt_d = d_fill_cnt_q;
        if (fill_done_s && (tgt_q == TGT_I)) begin
            i_fill_cnt_d = sat_inc16(i_fill_cnt_q);
        end else if (fill_done_s) begin
            d_fill_cnt_d = sat_inc16(d_fill_cnt_q);
        end else begin
            i_fill_cnt_d = i_fill_cnt_q;
        end
        stall_cyc_d = stall ? sat_inc16(stall_cyc_q) : stall_cyc_q;
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_fill_cnt_q <= 16'h0000;
            d_fill_cnt_q <= 16'h0000;
            stall_cyc_q  <= 16'h0000;
        end else begin
            i_fill_cnt_q <= i_fill_cnt_d;
            d_fill_cnt_q <= d_fill_cnt_d;
            stall_cyc_q  <= stall_cyc_d;
        end
    end

    assign i_fill_cnt = i_fill_cnt_q;
    assign d_fill_cnt = d_fill_cnt_q;
    assign stall_cyc  = stall_cyc_q;
`endif

endmodule

// File: tb/tb_cache_miss_arbiter.sv
// Directed bench for cache_miss_arbiter: timeline model of fills/stores plus per-test literal checks.
module tb_cache_miss_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_miss = 1'b0, d_miss = 1'b0, d_wr_req = 1'b0;
    logic [15:0] i_miss_addr = 16'h0000, d_miss_addr = 16'h0000;
    logic [15:0] d_wr_addr = 16'h0000, d_wr_data = 16'h0000;
    logic        mem_en, mem_wr, mem_valid = 1'b0;
    logic [15:0] mem_addr, mem_wdata, mem_rdata = 16'h0000, fill_data, fill_addr;
    logic        i_data_we, i_meta_we, d_data_we, d_meta_we, stall;
`ifdef CACHE_ARB_PERF_EN
    logic [15:0] i_fill_cnt, d_fill_cnt, stall_cyc;
`endif

    cache_miss_arbiter dut (
        .clk (clk), .rst_n (rst_n),
        .i_miss (i_miss), .i_miss_addr (i_miss_addr),
        .d_miss (d_miss), .d_miss_addr (d_miss_addr),
        .d_wr_req (d_wr_req), .d_wr_addr (d_wr_addr), .d_wr_data (d_wr_data),
        .mem_en (mem_en), .mem_wr (mem_wr), .mem_addr (mem_addr), .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata), .mem_valid (mem_valid),
        .fill_data (fill_data), .fill_addr (fill_addr),
        .i_data_we (i_data_we), .i_meta_we (i_meta_we),
        .d_data_we (d_data_we), .d_meta_we (d_meta_we),
`ifdef CACHE_ARB_PERF_EN
        .i_fill_cnt (i_fill_cnt), .d_fill_cnt (d_fill_cnt), .stall_cyc (stall_cyc),
`endif
        .stall (stall)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return (a ^ 16'h5A5A) + 16'h0013;
    endfunction

    // ---------------- memory4c model: read data valid 4 cycles after issue ----------------
    bit          cur_v;
    logic [15:0] cur_a;
    bit   [3:0]  pv;
    logic [15:0] pa [4];
    bit          stray = 1'b0;

    always @(negedge clk) begin
        cur_v = mem_en & ~mem_wr;
        cur_a = mem_addr;
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            pv = 4'b0000;
        end else begin
            pv    = {pv[2:0], cur_v};
            pa[3] = pa[2];
            pa[2] = pa[1];
            pa[1] = pa[0];
            pa[0] = cur_a;
        end
        #1;
        mem_valid = pv[3] | stray;
        mem_rdata = pv[3] ? mem_fn(pa[3]) : 16'hDEAD;
    end

    // ---------------- requesters: a cache drops its miss once the block is validated ----------------
    always @(posedge clk) begin
        #1;
        if (i_meta_we) i_miss = 1'b0;
        if (d_meta_we) d_miss = 1'b0;
        if (mem_en && mem_wr) d_wr_req = 1'b0;
    end

    // ---------------- timeline model: what every cycle must show ----------------
    int cyc = 0;
    int free_at = 0;
    bit          e_en [64], e_wr [64], e_busy [64], e_iw [64], e_im [64], e_dw [64], e_dm [64];
    bit   [15:0] e_addr [64], e_wdata [64], e_faddr [64], e_fdata [64];

    task automatic clear_slot(input int s);
        e_en[s] = 0; e_wr[s] = 0; e_busy[s] = 0; e_iw[s] = 0; e_im[s] = 0; e_dw[s] = 0; e_dm[s] = 0;
    endtask

    // Word k goes out in cycle c+k, returns in c+k+4 and is written one cycle later; DONE is c+12.
    task automatic sched_fill(input int c, input logic [11:0] base, input bit is_d);
        for (int k = 0; k < 8; k++) begin
            int s;
            logic [2:0] w;
            w = k[2:0];
            s = (c + k) % 64;
            e_en[s] = 1; e_addr[s] = {base, w, 1'b0};
            s = (c + 5 + k) % 64;
            if (is_d) e_dw[s] = 1; else e_iw[s] = 1;
            e_faddr[s] = {base, w, 1'b0};
            e_fdata[s] = mem_fn({base, w, 1'b0});
        end
        if (is_d) e_dm[(c + 12) % 64] = 1; else e_im[(c + 12) % 64] = 1;
        for (int k = 0; k <= 12; k++) e_busy[(c + k) % 64] = 1;
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            for (int s = 0; s < 64; s++) clear_slot(s);
            free_at = 0;
        end else if (cyc - 1 >= free_at) begin
            if (d_wr_req) begin
                e_en[cyc % 64] = 1; e_wr[cyc % 64] = 1; e_busy[cyc % 64] = 1;
                e_addr[cyc % 64] = d_wr_addr; e_wdata[cyc % 64] = d_wr_data;
                free_at = cyc + 1;
            end else if (d_miss) begin
                sched_fill(cyc, d_miss_addr[15:4], 1'b1);
                free_at = cyc + 13;
            end else if (i_miss) begin
                sched_fill(cyc, i_miss_addr[15:4], 1'b0);
                free_at = cyc + 13;
            end
        end
    end

    // ---------------- compare process and event logs ----------------
    logic [16:0] ev_log [$];
    logic [16:0] we_log [$];
    int iw_cnt = 0, im_cnt = 0, dw_cnt = 0, dm_cnt = 0;
    int i_since_rst = 0, d_since_rst = 0, stall_seen = 0;

    always @(negedge clk) begin : cmp
        int s;
        bit [6:0] ea;
        s = cyc % 64;
        ea = rst_n ? {e_en[s], e_wr[s], e_iw[s], e_im[s], e_dw[s], e_dm[s],
                      e_busy[s] | i_miss | d_miss} : 7'd0;
        check("ctrl{en,wr,iwe,imeta,dwe,dmeta,stall}",
              {25'd0, mem_en, mem_wr, i_data_we, i_meta_we, d_data_we, d_meta_we, stall}, {25'd0, ea});
        if (rst_n && e_en[s]) check("mem_addr", {16'd0, mem_addr}, {16'd0, e_addr[s]});
        if (rst_n && e_wr[s]) check("mem_wdata", {16'd0, mem_wdata}, {16'd0, e_wdata[s]});
        if (rst_n && (e_iw[s] || e_dw[s])) begin
            check("fill_addr", {16'd0, fill_addr}, {16'd0, e_faddr[s]});
            check("fill_data", {16'd0, fill_data}, {16'd0, e_fdata[s]});
        end
        clear_slot(s);
        if (mem_en) ev_log.push_back({mem_wr, mem_addr});
        if (i_data_we || d_data_we) we_log.push_back({d_data_we, fill_addr});
        iw_cnt += int'(i_data_we); im_cnt += int'(i_meta_we);
        dw_cnt += int'(d_data_we); dm_cnt += int'(d_meta_we);
        if (!rst_n) begin
            i_since_rst = 0; d_since_rst = 0; stall_seen = 0;
        end else begin
            i_since_rst += int'(i_meta_we); d_since_rst += int'(d_meta_we); stall_seen += int'(stall);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_logs();
        ev_log.delete(); we_log.delete();
        iw_cnt = 0; im_cnt = 0; dw_cnt = 0; dm_cnt = 0;
    endtask

    task automatic wait_served(input string name, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(posedge clk); #2;
            if (!i_miss && !d_miss && !d_wr_req) break;
        end
        check({name, "_wait_bound"}, {31'd0, k < budget}, 32'd1);
        repeat (3) @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        // 1: single I miss
        clear_logs();
        i_miss_addr = 16'h0124; i_miss = 1'b1;
        wait_served("t1", 40);
        check("t1_issues", ev_log.size(), 8);
        check("t1_first_addr", {15'd0, ev_log[0]}, {15'd0, 1'b0, 16'h0120});
        check("t1_last_addr", {15'd0, ev_log[7]}, {15'd0, 1'b0, 16'h012E});
        check("t1_i_data_we", iw_cnt, 8);
        check("t1_i_meta_we", im_cnt, 1);
        check("t1_d_we", dw_cnt + dm_cnt, 0);

        // 2: both misses together, D first then I, no interleave
        clear_logs();
        i_miss_addr = 16'h0300; d_miss_addr = 16'h4456;
        i_miss = 1'b1; d_miss = 1'b1;
        wait_served("t2", 80);
        check("t2_writes", we_log.size(), 16);
        check("t2_we0_is_d", {15'd0, we_log[0]}, {15'd0, 1'b1, 16'h4450});
        check("t2_we7_is_d", {15'd0, we_log[7]}, {15'd0, 1'b1, 16'h445E});
        check("t2_we8_is_i", {15'd0, we_log[8]}, {15'd0, 1'b0, 16'h0300});
        check("t2_metas", im_cnt * 16 + dm_cnt, 17);

        // 3: store with D miss pending; store goes first
        clear_logs();
        d_miss_addr = 16'h2010; d_miss = 1'b1;
        d_wr_addr = 16'h2002; d_wr_data = 16'hBEEF; d_wr_req = 1'b1;
        wait_served("t3", 60);
        check("t3_first_is_write", {15'd0, ev_log[0]}, {15'd0, 1'b1, 16'h2002});
        check("t3_fill_after", {15'd0, ev_log[1]}, {15'd0, 1'b0, 16'h2010});
        check("t3_events", ev_log.size(), 9);
        check("t3_d_meta", dm_cnt, 1);

        // 5: stray mem_valid in IDLE
        clear_logs();
        stray = 1'b1;
        @(posedge clk); #2 stray = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("t5_no_we", we_log.size() + im_cnt + dm_cnt, 0);
        check("t5_no_issue", ev_log.size(), 0);

        // 4: reset in the 5th FILL cycle, then restart
        begin
            int k;
            clear_logs();
            i_miss_addr = 16'h0840; i_miss = 1'b1;
            for (k = 0; k < 10; k++) begin
                @(posedge clk); #3;
                if (mem_en) break;
            end
            check("t4_fill_start_bound", {31'd0, k < 10}, 32'd1);
            repeat (4) @(posedge clk);
            #3 rst_n = 1'b0;
            #1;
            check("t4_async_ctrl", {25'd0, mem_en, mem_wr, i_data_we, i_meta_we, d_data_we, d_meta_we, stall}, 32'd0);
            check("t4_async_addr", {mem_addr, fill_addr}, 32'd0);
            check("t4_no_meta_before", im_cnt, 0);
            repeat (5) @(posedge clk);
            #2 rst_n = 1'b1;
            clear_logs();
            wait_served("t4", 40);
            check("t4_restart_word0", {15'd0, ev_log[0]}, {15'd0, 1'b0, 16'h0840});
            check("t4_restart_words", iw_cnt, 8);
            check("t4_restart_meta", im_cnt, 1);
        end

        // 6: one D fill then one I fill; since reset: two I fills, one D fill
        d_miss_addr = 16'h6000; d_miss = 1'b1;
        wait_served("t6d", 40);
        i_miss_addr = 16'h7010; i_miss = 1'b1;
        wait_served("t6i", 40);
        check("t6_i_fills", i_since_rst, 2);
        check("t6_d_fills", d_since_rst, 1);
`ifdef CACHE_ARB_PERF_EN
        @(posedge clk); #1;
        check("perf_i_fill_cnt", {16'd0, i_fill_cnt}, 32'd2);
        check("perf_d_fill_cnt", {16'd0, d_fill_cnt}, 32'd1);
        check("perf_stall_cyc", {16'd0, stall_cyc}, {16'd0, stall_seen[15:0]});
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
